// File: rtl/key_conditioner_pkg.sv
// Shared types and defaults for the KEY push-button conditioner.
// Optional auto-repeat is enabled by defining KEY_CONDITIONER_REPEAT_EN.
package key_cond_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_state_t;

  localparam int DEF_N_KEYS          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;     // 1 ms at 50 MHz
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 0.5 s at 50 MHz
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 0.1 s at 50 MHz

  // Bits needed to hold 0 .. max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the board pins, the conditioner and the user logic.
// The conditioner owns the slave side; the pin/user side owns master.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
) ();

  logic [N_KEYS-1:0] key_n;        // raw buttons, active-low
  logic [N_KEYS-1:0] key_level;    // debounced, active-high
  logic [N_KEYS-1:0] key_press;    // one-cycle pulse per accepted press or repeat
  logic [N_KEYS-1:0] key_release;  // one-cycle pulse per accepted release

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_conditioner_debounce_ch.sv
// One key channel: two-flop synchronizer, counting debounce FSM and, when
// KEY_CONDITIONER_REPEAT_EN is defined, an auto-repeat timer for held keys.
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Fails elaboration on settings the counters cannot honour.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  logic [1:0]    sync_q;
  logic          s;
  key_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          press_evt;
  logic          release_evt;
  logic          rpt_fire;

  assign s = ~sync_q[1];

  // NOTE: always_comb outputs get a default first so no path leaves them
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    press_evt   = 1'b0;
    release_evt = 1'b0;
    if (cnt_q == CNT_LAST) begin
      press_evt   = (state_q == FILT_DN) &&  s;
      release_evt = (state_q == FILT_UP) && !s;
    end
  end

  // NOTE: every register here uses <= so all flops update from the values
  // held before the edge; blocking = would let sync_q[1] see the new
  // sync_q[0] in the same cycle and collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= UP;
      cnt_q       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      key_press   <= press_evt | rpt_fire;
      key_release <= release_evt;

      unique case (state_q)
        UP: begin
          if (s) begin
            state_q <= FILT_DN;
            cnt_q   <= CNT_ONE;
          end
        end
        FILT_DN: begin
          // Any bounce drops all filter credit; the next attempt starts at 1.
          if (!s) begin
            state_q <= UP;
            cnt_q   <= '0;
          end else if (press_evt) begin
            state_q   <= DOWN;
            cnt_q     <= '0;
            key_level <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DOWN: begin
          if (!s) begin
            state_q <= FILT_UP;
            cnt_q   <= CNT_ONE;
          end
        end
        FILT_UP: begin
          if (s) begin
            state_q <= DOWN;
            cnt_q   <= '0;
          end else if (release_evt) begin
            state_q   <= UP;
            cnt_q     <= '0;
            key_level <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int            RW          = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RPT_ONE     = RW'(1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_first_q;  // still waiting for the longer initial delay
  logic          held;

  assign held = (state_q == DOWN) || (state_q == FILT_UP);

  // A release on the same edge wins; the repeat due then is dropped.
  always_comb begin
    rpt_fire = 1'b0;
    if (held && !release_evt) begin
      rpt_fire = rpt_first_q ? (rpt_cnt_q == DELAY_LAST) : (rpt_cnt_q == PERIOD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || press_evt || !held || release_evt) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + RPT_ONE;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions active-low DE1-SoC KEY buttons into debounced levels and pulses.
// Define KEY_CONDITIONER_REPEAT_EN to add auto-repeat press pulses on held keys.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic              clk,
  input logic              reset,
  key_conditioner_if.slave keys
);

  logic [N_KEYS-1:0] level_w;
  logic [N_KEYS-1:0] press_w;
  logic [N_KEYS-1:0] release_w;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_n      (keys.key_n[i]),
      .key_level  (level_w[i]),
      .key_press  (press_w[i]),
      .key_release(release_w[i])
    );
  end

  assign keys.key_level   = level_w;
  assign keys.key_press   = press_w;
  assign keys.key_release = release_w;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-side counterpart to the board top-level's display/LED output path: conditions the active-low DE1-SoC push-buttons (KEY) into clean, synchronous, active-high levels plus single-cycle press/release pulses for downstream logic. Each key gets a two-flop synchronizer and a counter-based debounce state machine. An optional auto-repeat mode re-emits press pulses while a key is held. It instantiates directly in the top-level between KEY and the user logic.

## Interface
- N_KEYS, 4, number of independent key channels
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles required to accept a change (1 ms at 50 MHz); must be ≥ 2
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (auto-repeat build only)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (auto-repeat build only)
- clk  input  1  single system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- key_n  input  N_KEYS  raw asynchronous buttons, active-low (0 = pressed)
- key_level  output  N_KEYS  debounced state, active-high (1 = pressed)
- key_press  output  N_KEYS  one-cycle pulse on accepted press (and on repeats if enabled)
- key_release  output  N_KEYS  one-cycle pulse on accepted release

## Operation
- Channels are fully independent. Any mix of keys may change in the same cycle.
- Synchronizer: two flops per key, reset to 1 (released). The output is inverted to give active-high sample s.
- Per-channel FSM states:
  - UP: key_level=0; if s=1, go to FILT_DN with cnt=1.
  - FILT_DN: if s=0, go back to UP with cnt=0; else if cnt==DEBOUNCE_CYCLES-1, go to DOWN with key_level=1 and key_press=1; else cnt++.
  - DOWN: key_level=1; if s=0, go to FILT_UP with cnt=1.
  - FILT_UP: mirror of FILT_DN; on completion go to UP with key_level=0 and key_release=1.
- A bounce resets filtering. There are no partial credits: the counter always restarts from 1.
- cnt width is $clog2(DEBOUNCE_CYCLES). It never wraps, because it saturates by construction at DEBOUNCE_CYCLES-1.
- key_press and key_release for one channel are never asserted in the same cycle.
- Reset values: key_level=0, key_press=0, key_release=0, FSM=UP, cnt=0, sync flops=1.
- Reset mid-filter or while DOWN abandons all state without emitting pulses.
- If a key is still held when reset deasserts, it is debounced afresh and produces a normal press.

## Timing
- Registered outputs only; there is no combinational path from key_n.
- Raw edge sampled at edge k: s is valid after edge k+1, and key_level/pulse are asserted after edge k+1+DEBOUNCE_CYCLES.
- A pulse is high for exactly one cycle, i.e. it deasserts after the following edge.
- Minimum accepted press width is DEBOUNCE_CYCLES synchronized cycles. Shorter glitches produce no output.
- Reset asserted on edge k forces reset values after edge k, regardless of the other inputs.

## Configuration
- KEY_CONDITIONER_REPEAT_EN defined:
  - In DOWN, a per-channel repeat counter starts at the press pulse.
  - key_press pulses again REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles while the channel stays in DOWN or FILT_UP.
  - The repeat counter clears on entry to UP and on reset.
  - Repeat pulses never coincide with key_release.
- KEY_CONDITIONER_REPEAT_EN undefined: no repeat counters exist, REPEAT_* parameters are ignored, and exactly one key_press pulse is emitted per accepted press.

## Structure
- Package key_cond_pkg holds:
  - typedef enum logic [1:0] {UP, FILT_DN, DOWN, FILT_UP} key_state_t
  - default parameter constants
- Sub-module key_debounce_ch contains one channel: synchronizer, FSM, counters and optional repeat logic. The top uses a generate loop over N_KEYS.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4; the repeat scenario additionally uses REPEAT_DELAY=8 and REPEAT_PERIOD=3.

1. Reset with key_n=4'b1111 -> all outputs 0. Drive key_n[0]=0 before edge 0 -> key_level[0]=1 and key_press[0]=1 after edge 5; press 0 after edge 6.
2. While key 0 is held, bounce key_n[0] high for 1 cycle -> no release pulse; key_level[0] stays 1.
3. Release key 0 cleanly -> key_release[0]=1 for exactly 1 cycle, 5 edges after the first sampled high; key_level[0]=0.
4. Keys 1 and 3 pressed in the same cycle -> key_press=4'b1010 for one cycle; keys 0 and 2 are unaffected.
5. Assert reset 2 cycles into FILT_DN with key still held, release reset -> no pulse during reset; a press pulse arrives 5 edges after reset deasserts.
6. With KEY_CONDITIONER_REPEAT_EN, hold key 2 -> key_press[2] pulses at the press, then at +8, +11 and +14 cycles. On release, repeats stop and one key_release[2] pulse is emitted.
